// File: rtl/rgb2bayer_mosaic.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rgb2bayer_mosaic                                           |
// | Description : Re-mosaics a 24-bit RGB Avalon-ST video stream into an     |
// |               8-bit Bayer raw stream. One registered output stage with   |
// |               backpressure, configured via a small Avalon-MM slave.      |
// |               Optional statistics registers: RGB2BAYER_STATS_EN.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module rgb2bayer_mosaic #(
  parameter int WID = 1920,
  parameter int HEI = 1080,
  parameter int PAT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] sink_data,
  input  logic        sink_sop,
  input  logic        sink_eop,
  input  logic        sink_valid,
  output logic        sink_ready,
  output logic [7:0]  source_data,
  output logic        source_sop,
  output logic        source_eop,
  output logic        source_valid,
  input  logic        source_ready,
  input  logic [2:0]  slave_addr,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  input  logic        slave_read,
  output logic [31:0] slave_readdata
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_VIDEO   = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  // Configuration registers and their per-frame shadows
  logic        r_go;
  logic [15:0] r_width;
  logic [15:0] r_height;
  logic [1:0]  r_pattern;
  logic [15:0] r_wsh;
  logic [1:0]  r_psh;

  // Pixel position within the current frame
  logic [15:0] r_x;
  logic [15:0] r_y;

  // Output stage
  logic [7:0]  r_src_data;
  logic        r_src_sop;
  logic        r_src_eop;
  logic        r_src_valid;

  logic        w_go_eff;
  logic        w_ready;
  logic        w_accept;
  logic        w_load;
  logic [7:0]  w_ld_data;
  logic        w_ld_sop;
  logic        w_ld_eop;
  logic        w_start;
  logic        w_vid_beat;
  logic        w_ex;
  logic        w_ey;
  logic [7:0]  w_pix;
  logic [15:0] w_wlast;
  logic        w_unused;

  // Upper write-data bits are never stored by any register
  assign w_unused = ^slave_writedata[31:16] ^ slave_read;

  // A zero width behaves as a width of one pixel
  assign w_wlast = (r_wsh == 16'd0) ? 16'd0 : (r_wsh - 16'd1);

  // Handshake, next-state decode and output-beat selection
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_ld_data   = 8'h00;
    w_ld_sop    = 1'b0;
    w_ld_eop    = 1'b0;
    w_start     = 1'b0;
    w_vid_beat  = 1'b0;
    // go only gates the start of a packet; a packet in flight always completes
    w_go_eff    = (r_state == S_IDLE) ? r_go : 1'b1;
    w_ready     = w_go_eff & (~r_src_valid | source_ready);
    w_accept    = sink_valid & w_ready;
    w_ex        = r_x[0] ^ r_psh[0];
    w_ey        = r_y[0] ^ r_psh[1];
    case ({w_ey, w_ex})
      2'b00:   w_pix = sink_data[23:16];
      2'b11:   w_pix = sink_data[7:0];
      default: w_pix = sink_data[15:8];
    endcase
    if (w_accept) begin
      if (sink_sop) begin
        // Any sop restarts packet parsing, aborting whatever was in flight
        if (sink_data[3:0] == 4'd0) begin
          w_load      = 1'b1;
          w_ld_data   = 8'h00;
          w_ld_sop    = 1'b1;
          w_ld_eop    = sink_eop;
          w_start     = 1'b1;
          w_state_nxt = sink_eop ? S_IDLE : S_VIDEO;
        end else begin
          w_state_nxt = sink_eop ? S_IDLE : S_DISCARD;
        end
      end else begin
        case (r_state)
          S_VIDEO: begin
            w_load     = 1'b1;
            w_ld_data  = w_pix;
            w_ld_eop   = sink_eop;
            w_vid_beat = 1'b1;
            if (sink_eop) w_state_nxt = S_IDLE;
          end
          S_DISCARD: begin
            if (sink_eop) w_state_nxt = S_IDLE;
          end
          default: begin
            w_state_nxt = S_IDLE;
          end
        endcase
      end
    end
  end

  assign sink_ready = w_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Latch width/pattern at every accepted sop so mid-frame writes wait a frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wsh <= 16'(WID);
      r_psh <= 2'(PAT);
    end else if (w_accept && sink_sop) begin
      r_wsh <= r_width;
      r_psh <= r_pattern;
    end
  end

  // Pixel counters: x wraps at the line end, y counts lines and saturates
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x <= 16'd0;
      r_y <= 16'd0;
    end else if (w_start) begin
      r_x <= 16'd0;
      r_y <= 16'd0;
    end else if (w_vid_beat) begin
      if (r_x == w_wlast) begin
        r_x <= 16'd0;
        if (r_y != 16'hFFFF) r_y <= r_y + 16'd1;
      end else begin
        r_x <= r_x + 16'd1;
      end
    end
  end

  // Output register: load on a producing beat, hold under backpressure
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_src_valid <= 1'b0;
      r_src_data  <= 8'h00;
      r_src_sop   <= 1'b0;
      r_src_eop   <= 1'b0;
    end else if (w_load) begin
      r_src_valid <= 1'b1;
      r_src_data  <= w_ld_data;
      r_src_sop   <= w_ld_sop;
      r_src_eop   <= w_ld_eop;
    end else if (source_ready) begin
      r_src_valid <= 1'b0;
    end
  end

  assign source_valid = r_src_valid;
  assign source_data  = r_src_data;
  assign source_sop   = r_src_sop;
  assign source_eop   = r_src_eop;

  // Control register writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_go      <= 1'b0;
      r_width   <= 16'(WID);
      r_height  <= 16'(HEI);
      r_pattern <= 2'(PAT);
    end else if (slave_write) begin
      case (slave_addr)
        3'd0:    r_go      <= slave_writedata[0];
        3'd2:    r_width   <= slave_writedata[15:0];
        3'd3:    r_height  <= slave_writedata[15:0];
        3'd4:    r_pattern <= slave_writedata[1:0];
        default: ;
      endcase
    end
  end

`ifdef RGB2BAYER_STATS_EN
  logic [31:0] r_frame_count;
  logic        r_size_err;
  logic        w_video_eop;
  logic        w_size_bad;

  assign w_video_eop = w_vid_beat & sink_eop;
  assign w_size_bad  = (r_x != w_wlast) | (r_y != (r_height - 16'd1));

  // Frame counter and sticky frame-size error; a new error wins over a clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_count <= 32'd0;
      r_size_err    <= 1'b0;
    end else begin
      if (w_video_eop) r_frame_count <= r_frame_count + 32'd1;
      if (slave_write && (slave_addr == 3'd6) && slave_writedata[0]) r_size_err <= 1'b0;
      if (w_video_eop && w_size_bad) r_size_err <= 1'b1;
    end
  end
`endif

  // Register read mux, combinational from the address
  always_comb begin
    slave_readdata = 32'd0;
    case (slave_addr)
      3'd0:    slave_readdata = {31'd0, r_go};
      3'd1:    slave_readdata = {31'd0, (r_state != S_IDLE)};
      3'd2:    slave_readdata = {16'd0, r_width};
      3'd3:    slave_readdata = {16'd0, r_height};
      3'd4:    slave_readdata = {30'd0, r_pattern};
`ifdef RGB2BAYER_STATS_EN
      3'd5:    slave_readdata = r_frame_count;
      3'd6:    slave_readdata = {31'd0, r_size_err};
`endif
      default: slave_readdata = 32'd0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_rgb2bayer_mosaic.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_rgb2bayer_mosaic                                        |
// | Description : Directed table-driven bench for rgb2bayer_mosaic.          |
// |               Optional statistics checks follow RGB2BAYER_STATS_EN.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_rgb2bayer_mosaic;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] sink_data;
  logic        sink_sop;
  logic        sink_eop;
  logic        sink_valid;
  logic        sink_ready;
  logic [7:0]  source_data;
  logic        source_sop;
  logic        source_eop;
  logic        source_valid;
  logic        source_ready;
  logic [2:0]  slave_addr;
  logic        slave_write;
  logic [31:0] slave_writedata;
  logic        slave_read;
  logic [31:0] slave_readdata;

  rgb2bayer_mosaic dut (
    .clk             (clk),
    .rst             (rst),
    .sink_data       (sink_data),
    .sink_sop        (sink_sop),
    .sink_eop        (sink_eop),
    .sink_valid      (sink_valid),
    .sink_ready      (sink_ready),
    .source_data     (source_data),
    .source_sop      (source_sop),
    .source_eop      (source_eop),
    .source_valid    (source_valid),
    .source_ready    (source_ready),
    .slave_addr      (slave_addr),
    .slave_write     (slave_write),
    .slave_writedata (slave_writedata),
    .slave_read      (slave_read),
    .slave_readdata  (slave_readdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] d;
    logic        sop;
    logic        eop;
    logic        ev;
    logic [7:0]  ed;
    logic        esop;
    logic        eeop;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [23:0] PIX = 24'h112233;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  task automatic add(input logic [23:0] d, input logic s, input logic e, input logic ev,
                     input logic [7:0] ed, input logic es, input logic ee);
    vec_t v;
    v.d = d; v.sop = s; v.eop = e; v.ev = ev; v.ed = ed; v.esop = es; v.eeop = ee;
    tbl.push_back(v);
  endtask

  // Video type beat followed by pixels of the constant colour PIX
  task automatic add_type();
    add(24'h000000, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic add_px(input logic [7:0] ed, input logic last);
    add(PIX, 1'b0, last, 1'b1, ed, 1'b0, last);
  endtask

  // One beat per cycle; output is checked one cycle after acceptance
  task automatic apply(input int idx);
    sink_data  = tbl[idx].d;
    sink_sop   = tbl[idx].sop;
    sink_eop   = tbl[idx].eop;
    sink_valid = 1'b1;
    #1;
    chk($sformatf("sink_ready[%0d]", idx), {31'd0, sink_ready}, 32'd1);
    @(posedge clk);
    #1;
    if (tbl[idx].ev)
      chk($sformatf("beat[%0d]", idx),
          {21'd0, source_valid, source_sop, source_eop, source_data},
          {21'd0, 1'b1, tbl[idx].esop, tbl[idx].eeop, tbl[idx].ed});
    else
      chk($sformatf("nobeat[%0d]", idx), {31'd0, source_valid}, 32'd0);
  endtask

  task automatic run(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) apply(i);
    sink_valid = 1'b0;
    sink_sop   = 1'b0;
    sink_eop   = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    slave_addr      = a;
    slave_writedata = d;
    slave_write     = 1'b1;
    @(posedge clk);
    #1;
    slave_write     = 1'b0;
  endtask

  task automatic rdchk(input string name, input logic [2:0] a, input logic [31:0] req);
    slave_addr = a;
    slave_read = 1'b1;
    #1;
    chk(name, slave_readdata, req);
    slave_read = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fa, fb, fc, fw, fd;

    // Frame A: RGGB, width 4, two lines
    fa = tbl.size();
    add_type();
    add_px(8'h11, 0); add_px(8'h22, 0); add_px(8'h11, 0); add_px(8'h22, 0);
    add_px(8'h22, 0); add_px(8'h33, 0); add_px(8'h22, 0); add_px(8'h33, 1);
    // Frame B: BGGR, width 4, two lines
    fb = tbl.size();
    add_type();
    add_px(8'h33, 0); add_px(8'h22, 0); add_px(8'h33, 0); add_px(8'h22, 0);
    add_px(8'h22, 0); add_px(8'h11, 0); add_px(8'h22, 0); add_px(8'h11, 1);
    // Control packet: nothing comes out
    fc = tbl.size();
    add(24'h00000F, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    add(PIX,        1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    add(PIX,        1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    // Frame C: RGGB, width 2, two lines
    fw = tbl.size();
    add_type();
    add_px(8'h11, 0); add_px(8'h22, 0); add_px(8'h22, 0); add_px(8'h33, 1);
    // Frame D: RGGB, width 4, short by one pixel
    fd = tbl.size();
    add_type();
    add_px(8'h11, 0); add_px(8'h22, 0); add_px(8'h11, 0); add_px(8'h22, 0);
    add_px(8'h22, 0); add_px(8'h33, 0); add_px(8'h22, 1);

    rst = 1'b1;
    sink_data = 24'd0; sink_sop = 1'b0; sink_eop = 1'b0; sink_valid = 1'b0;
    source_ready = 1'b1;
    slave_addr = 3'd0; slave_write = 1'b0; slave_writedata = 32'd0; slave_read = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    chk("rst_out", {20'd0, source_valid, source_sop, source_eop, 1'b0, source_data}, 32'd0);
    chk("rst_sink_ready", {31'd0, sink_ready}, 32'd0);
    rdchk("rst_ctrl", 3'd0, 32'd0);
    rdchk("rst_status", 3'd1, 32'd0);
    rdchk("rst_width", 3'd2, 32'd1920);
    rdchk("rst_height", 3'd3, 32'd1080);
    rdchk("rst_pattern", 3'd4, 32'd0);
    rdchk("rst_unmapped", 3'd7, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    wr(3'd2, 32'd4);
    wr(3'd3, 32'd2);
    wr(3'd4, 32'd0);
    wr(3'd0, 32'd1);
    rdchk("go_set", 3'd0, 32'd1);

    // RGGB frame
    run(fa, fa + 8);

    // BGGR frame
    wr(3'd4, 32'd3);
    rdchk("pattern3", 3'd4, 32'd3);
    run(fb, fb + 8);
    wr(3'd4, 32'd0);

    // Backpressure mid-line: the held beat must not be lost or repeated
    run(fa, fa + 2);
    source_ready = 1'b0;
    sink_data = PIX; sink_sop = 1'b0; sink_eop = 1'b0; sink_valid = 1'b1;
    #1;
    chk("bp_ready_pre", {31'd0, sink_ready}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp_hold[%0d]", i), {23'd0, source_valid, source_data}, {23'd0, 1'b1, 8'h22});
      chk($sformatf("bp_ready[%0d]", i), {31'd0, sink_ready}, 32'd0);
    end
    source_ready = 1'b1;
    run(fa + 3, fa + 8);

    // Control packet then video frame
    run(fc, fc + 2);
    run(fa, fa + 8);

    // Mid-frame width change applies to the next frame only
    run(fa, fa + 4);
    wr(3'd2, 32'd2);
    rdchk("busy_mid", 3'd1, 32'd1);
    rdchk("width2", 3'd2, 32'd2);
    run(fa + 5, fa + 8);
    run(fw, fw + 4);

    // Clearing go mid-packet completes the packet, then stalls
    wr(3'd2, 32'd4);
    run(fa, fa + 3);
    wr(3'd0, 32'd0);
    run(fa + 4, fa + 8);
    #1;
    chk("go_stall", {31'd0, sink_ready}, 32'd0);
    wr(3'd0, 32'd1);

    // Reset mid-packet
    run(fa, fa + 2);
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", {31'd0, source_valid}, 32'd0);
    rdchk("rst_mid_status", 3'd1, 32'd0);
    rdchk("rst_mid_width", 3'd2, 32'd1920);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wr(3'd2, 32'd4);
    wr(3'd3, 32'd2);
    wr(3'd0, 32'd1);

    // Two good frames then a short one
    run(fa, fa + 8);
    run(fa, fa + 8);
    run(fd, fd + 7);
`ifdef RGB2BAYER_STATS_EN
    rdchk("frame_count", 3'd5, 32'd3);
    rdchk("size_err_set", 3'd6, 32'd1);
    wr(3'd6, 32'd1);
    rdchk("size_err_clr", 3'd6, 32'd0);
`else
    wr(3'd5, 32'hFFFF_FFFF);
    wr(3'd6, 32'hFFFF_FFFF);
    rdchk("addr5_zero", 3'd5, 32'd0);
    rdchk("addr6_zero", 3'd6, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rgb2bayer_mosaic.md
Name: rgb2bayer_mosaic

Overview:
- Re-mosaics a 24-bit RGB Avalon-ST video stream into an 8-bit Bayer raw stream; the inverse of the debayer path.
- Used to build camera-sensor emulation and debayer loopback benches inside the VIP pipeline.
- Configured through a small Avalon-MM slave: go, width, height and CFA pattern.
- Emits one 8-bit sample per input pixel, with one registered output stage and backpressure.

Parameters:
- WID, 1920: reset value of the width register (pixels per line).
- HEI, 1080: reset value of the height register (lines per frame).
- PAT, 0: reset value of the CFA pattern register. 0=RGGB, 1=GRBG, 2=GBRG, 3=BGGR.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- sink_data  in  24  RGB pixel: [23:16] R, [15:8] G, [7:0] B
- sink_sop  in  1  start of packet
- sink_eop  in  1  end of packet
- sink_valid  in  1  beat valid
- sink_ready  out  1  beat accepted when sink_valid & sink_ready
- source_data  out  8  Bayer sample, or packet-type beat
- source_sop  out  1  start of packet
- source_eop  out  1  end of packet
- source_valid  out  1  output beat valid
- source_ready  in  1  downstream ready
- slave_addr  in  3  register address
- slave_write  in  1  write strobe
- slave_writedata  in  32  write data
- slave_read  in  1  read strobe
- slave_readdata  out  32  read data, combinational from slave_addr

Behaviour:
- Reset: all outputs 0; registers width=WID, height=HEI, pattern=PAT, go=0; state IDLE; x=y=0.
- Register map, unmapped addresses read 0:
  - 0: ctrl, bit0 go, R/W.
  - 1: status, bit0 busy (state!=IDLE), RO.
  - 2: width[15:0], R/W.
  - 3: height[15:0], R/W.
  - 4: pattern[1:0], R/W.
- Shadowing:
  - width and pattern are copied to shadow registers on every accepted sop beat. A mid-frame write never affects the current frame.
  - go is sampled only in IDLE. Clearing go mid-packet finishes the current packet, then stalls.
- Handshake:
  - sink_ready = go_eff & (~source_valid | source_ready).
  - An accepted beat produces its output beat on the next cycle. Latency is exactly 1 cycle.
  - The output register holds its data while source_valid & ~source_ready.
- State machine (IDLE, VIDEO, DISCARD). Transitions happen on accepted beats only:
  - sop beat with data[3:0]==0: forward one type beat (data 8'h00, sop=1, eop=sink_eop), reset x=y=0, go to VIDEO. If that beat also has eop, stay IDLE.
  - sop beat with data[3:0]!=0: output nothing, go to DISCARD.
  - VIDEO: each beat outputs one Bayer sample. eop is propagated to source_eop, then go to IDLE.
  - DISCARD: beats are consumed with no output until eop, then go to IDLE.
  - A sop beat in VIDEO or DISCARD aborts the current packet without an output eop and is processed as a new sop from IDLE.
  - Non-sop beats in IDLE are consumed and dropped.
- Pixel mapping:
  - ex = x[0]^pat[0], ey = y[0]^pat[1].
  - (ey,ex): (0,0)=R, (0,1)=G, (1,0)=G, (1,1)=B.
- Counters:
  - x increments per video beat and wraps to 0 after width_shadow-1; y increments on each wrap.
  - y saturates at 16'hFFFF. height is informational only; packet length is governed by eop.
  - width_shadow=0 is treated as 1.
- Reset mid-packet returns to IDLE immediately and deasserts source_valid.

Optional Feature:
- Macro RGB2BAYER_STATS_EN.
- When defined:
  - addr 5 is frame_count[31:0], RO. It increments on each video eop that is output and wraps at 2^32.
  - addr 6 bit0 is size_err, sticky. It is set when a video eop arrives with x!=width_shadow-1 or y!=height-1. Writing 1 to addr 6 clears it.
- When undefined: addr 5 and addr 6 read 0, writes to them are ignored, and no counter logic is instantiated.

Test Plan:
- go=1, width=4, height=2, pattern=0, frame of 8 pixels each R=8'h11 G=8'h22 B=8'h33 -> output 00, 11,22,11,22, 22,33,22,33; eop on the last beat; each beat 1 cycle after its input.
- Same frame with pattern=3 (BGGR) -> 00, 33,22,33,22, 22,11,22,11.
- source_ready held low 5 cycles mid-line -> sink_ready low for those cycles; output beat stable; no sample lost or duplicated.
- Control packet (sop data 24'h00000F, 3 beats, eop) followed by a video frame -> nothing output for the control packet; video frame output intact.
- Write width=2 mid-frame with width=4 -> current frame still wraps at 4; next frame wraps at 2.
- With RGB2BAYER_STATS_EN: two good frames then one 7-pixel frame -> frame_count=3, size_err=1; write 1 to addr 6 -> size_err=0.
